// File: rtl/s2p_pkg.sv
// Shared types and sizing helpers for the s2p_deser_en deserializer.
// S2P_PARITY_CHK_EN adds one trailing even-parity bit to each frame.
package s2p_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        LOAD = 2'd1,
        DROP = 2'd2
    } s2p_outcome_e;

`ifdef S2P_PARITY_CHK_EN
    localparam bit S2P_PARITY = 1'b1;
`else
    localparam bit S2P_PARITY = 1'b0;
`endif

    function automatic int s2p_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int s2p_frame_len(input int width);
        return S2P_PARITY ? width + 1 : width;
    endfunction

endpackage

// File: rtl/s2p_bit_counter.sv
// Wrapping bit counter for the deserializer: clr restarts, en advances,
// tc_o flags the last bit position of a frame.
module s2p_bit_counter #(
    parameter int CNT_W = 4,
    parameter int LAST  = 7
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LAST);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clr beats en, wrap to zero after the last position
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == LAST_C) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == LAST_C);

endmodule

// File: rtl/s2p_deser_en.sv
// Enable-qualified serial-to-parallel deserializer with valid/ready output
// and sticky overflow; S2P_PARITY_CHK_EN adds a trailing parity bit and par_err.
module s2p_deser_en
    import s2p_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int S2P_CNT_W     = s2p_cnt_w(WIDTH),
    localparam int S2P_FRAME_LEN = s2p_frame_len(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 d,
    input  logic                 clr,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [S2P_CNT_W-1:0] bit_cnt,
    output logic                 ovf
`ifdef S2P_PARITY_CHK_EN
    ,
    output logic                 par_err
`endif
);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] word_s;
    logic             tc_s;
    logic             complete_s;
    logic             slot_free_s;
    s2p_outcome_e     outcome_s;

    s2p_bit_counter #(
        .CNT_W (S2P_CNT_W),
        .LAST  (S2P_FRAME_LEN - 1)
    ) u_bit_counter (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (clr),
        .en_i    (en),
        .cnt_o   (bit_cnt),
        .tc_o    (tc_s)
    );

    assign shifted_s = MSB_FIRST ? {sr_q[WIDTH-2:0], d} : {d, sr_q[WIDTH-1:1]};

`ifdef S2P_PARITY_CHK_EN
    // With parity the data bits are already in sr_q when the parity bit arrives
    logic par_err_q, par_err_d;
    logic par_s;
    assign word_s = sr_q;
    assign par_s  = (^sr_q) ^ d;
`else
    assign word_s = shifted_s;
`endif

    assign complete_s  = en & tc_s & ~clr;
    assign slot_free_s = ~dout_valid_q | dout_ready;

    // Classify this edge's completion against output slot occupancy
    always_comb begin
        outcome_s = NONE;
        if (!complete_s) begin
            outcome_s = NONE;
        end else if (slot_free_s) begin
            outcome_s = LOAD;
        end else begin
            outcome_s = DROP;
        end
    end

    // Shift register: cleared by clr and at frame completion
    always_comb begin
        sr_d = sr_q;
        if (clr) begin
            sr_d = '0;
        end else if (en) begin
            if (tc_s) begin
                sr_d = '0;
            end else begin
                sr_d = shifted_s;
            end
        end else begin
            sr_d = sr_q;
        end
    end

    // Output slot, handshake and overflow next state
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        ovf_d        = ovf_q;
`ifdef S2P_PARITY_CHK_EN
        par_err_d    = par_err_q;
`endif
        case (outcome_s)
            LOAD: begin
                dout_d       = word_s;
                dout_valid_d = 1'b1;
`ifdef S2P_PARITY_CHK_EN
                par_err_d    = par_s;
`endif
            end
            DROP: begin
                ovf_d = 1'b1;
            end
            NONE: begin
                if (dout_valid_q && dout_ready) begin
                    dout_valid_d = 1'b0;
                end else begin
                    dout_valid_d = dout_valid_q;
                end
            end
            default: begin
                dout_d       = dout_q;
                dout_valid_d = dout_valid_q;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef S2P_PARITY_CHK_EN
            par_err_q    <= 1'b0;
`endif
        end else begin
            sr_q         <= sr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            ovf_q        <= ovf_d;
`ifdef S2P_PARITY_CHK_EN
            par_err_q    <= par_err_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign ovf        = ovf_q;
`ifdef S2P_PARITY_CHK_EN
    assign par_err    = par_err_q;
`endif

endmodule

// File: tb/tb_s2p_deser_en.sv
// Directed bench for s2p_deser_en (MSB-first main DUT plus an LSB-first twin).
module tb_s2p_deser_en;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       d = 1'b0;
    logic       clr = 1'b0;
    logic       dout_ready = 1'b0;
    logic [7:0] dout, dout2;
    logic       dout_valid, dout_valid2;
    logic [3:0] bit_cnt, bit_cnt2;
    logic       ovf, ovf2;
`ifdef S2P_PARITY_CHK_EN
    logic       par_err, par_err2;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    s2p_deser_en #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .en(en), .d(d), .clr(clr),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .bit_cnt(bit_cnt), .ovf(ovf)
`ifdef S2P_PARITY_CHK_EN
        , .par_err(par_err)
`endif
    );

    s2p_deser_en #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .en(en), .d(d), .clr(clr),
        .dout(dout2), .dout_valid(dout_valid2), .dout_ready(dout_ready),
        .bit_cnt(bit_cnt2), .ovf(ovf2)
`ifdef S2P_PARITY_CHK_EN
        , .par_err(par_err2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        en = 1'b1;
        d  = b;
        tick();
        en = 1'b0;
    endtask

    // Sends w MSB-first in time; dout_ready is set to rdy_last for the completing edge
    task automatic send_word(input logic [7:0] w, input logic flip, input logic rdy_last);
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
`ifdef S2P_PARITY_CHK_EN
        send_bit(w[0]);
        dout_ready = rdy_last;
        send_bit((^w) ^ flip);
`else
        dout_ready = rdy_last;
        send_bit(w[0]);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        tick();
        do_reset();
        check("rst_dout",  dout, 32'h0);
        check("rst_valid", dout_valid, 32'h0);
        check("rst_ovf",   ovf, 32'h0);
        check("rst_cnt",   bit_cnt, 32'h0);

        // Basic word B2; LSB-first twin sees the same stream as 4D
        dout_ready = 1'b0;
        for (int i = 7; i >= 1; i--) send_bit(8'hB2 >> i);
        check("cnt_7", bit_cnt, 32'd7);
        check("valid_early", dout_valid, 32'h0);
`ifdef S2P_PARITY_CHK_EN
        send_bit(1'b0);
        send_bit(1'b0);
`else
        send_bit(1'b0);
`endif
        check("b2_dout",  dout, 32'hB2);
        check("b2_valid", dout_valid, 32'h1);
        check("b2_cnt",   bit_cnt, 32'h0);
        check("lsb_4d",   dout2, 32'h4D);
        dout_ready = 1'b1;
        tick();
        check("accept_valid", dout_valid, 32'h0);
        check("accept_hold",  dout, 32'hB2);

        // Enable gap between bits 4 and 5 with d toggling
        dout_ready = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        for (int i = 0; i < 3; i++) begin
            d = i[0];
            tick();
            check("gap_cnt", bit_cnt, 32'd4);
        end
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
`ifdef S2P_PARITY_CHK_EN
        send_bit(1'b0);
`endif
        check("gap_dout",  dout, 32'hB2);
        check("gap_valid", dout_valid, 32'h1);

        // Slot busy: FF is dropped
        send_word(8'hFF, 1'b0, 1'b0);
        check("ovf_dout",  dout, 32'hB2);
        check("ovf_flag",  ovf, 32'h1);
        check("ovf_valid", dout_valid, 32'h1);
        dout_ready = 1'b1;
        tick();
        check("ovf_drain_valid", dout_valid, 32'h0);
        check("ovf_sticky",      ovf, 32'h1);

        // clr mid-word discards partial bits and leaves ovf alone
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("pre_clr_cnt", bit_cnt, 32'd5);
        clr = 1'b1; en = 1'b1; d = 1'b1;
        tick();
        clr = 1'b0; en = 1'b0;
        check("clr_cnt",   bit_cnt, 32'h0);
        check("clr_ovf",   ovf, 32'h1);
        check("clr_valid", dout_valid, 32'h0);
        send_word(8'hA5, 1'b0, 1'b0);
        check("a5_dout",  dout, 32'hA5);
        check("a5_valid", dout_valid, 32'h1);

        // Reset mid-word while a word is held
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        do_reset();
        check("mid_rst_dout",  dout, 32'h0);
        check("mid_rst_valid", dout_valid, 32'h0);
        check("mid_rst_ovf",   ovf, 32'h0);
        check("mid_rst_cnt",   bit_cnt, 32'h0);

        // Back-to-back: accept coincides with completion of 0F
        send_word(8'hB2, 1'b0, 1'b0);
        check("b2b_first", dout, 32'hB2);
        send_word(8'h0F, 1'b0, 1'b1);
        check("b2b_valid", dout_valid, 32'h1);
        check("b2b_dout",  dout, 32'h0F);
        check("b2b_ovf",   ovf, 32'h0);
        en = 1'b0;
        tick();
        check("b2b_drain", dout_valid, 32'h0);

`ifdef S2P_PARITY_CHK_EN
        dout_ready = 1'b0;
        send_word(8'hB2, 1'b0, 1'b0);
        check("par_ok_dout", dout, 32'hB2);
        check("par_ok",      par_err, 32'h0);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        send_word(8'hB2, 1'b1, 1'b0);
        check("par_bad_dout", dout, 32'hB2);
        check("par_bad",      par_err, 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/s2p_deser_en.md
Name: s2p_deser_en

Overview:
- Serial-to-parallel deserializer that sits directly downstream of the enable-gated bit register.
- Consumes its registered bit stream and bit-enable, and packs WIDTH qualified bits into a parallel word.
- Presents each word on a valid/ready output port, with a sticky overflow flag for dropped words.

Parameters:
- WIDTH, 8, number of data bits per word (legal range 2..32).
- MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first bit lands in dout[0].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  bit qualifier; d is sampled only when en=1.
- d  input  1  serial data bit.
- clr  input  1  synchronous frame restart; discards the partial word.
- dout  output  WIDTH  completed word, held stable while dout_valid=1.
- dout_valid  output  1  word available.
- dout_ready  input  1  consumer accepts the word when dout_valid & dout_ready at a clk edge.
- bit_cnt  output  $clog2(WIDTH+1)  number of bits collected in the current partial word.
- ovf  output  1  sticky overflow flag.

Behaviour:
- Reset (reset=1 at clk edge): shift register=0, bit_cnt=0, dout=0, dout_valid=0, ovf=0. Reset overrides all other inputs, including mid-word and while dout_valid=1.
- Priority each edge: reset > clr > en.
- clr=1: shift register and bit_cnt cleared; dout, dout_valid and ovf are unaffected. The en/d values in that cycle are ignored.
- en=0: shift register and bit_cnt hold.
- en=1 with bit_cnt<WIDTH-1: d is shifted in and bit_cnt increments.
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], d}.
  - MSB_FIRST=0: sr <= {d, sr[WIDTH-1:1]}.
- en=1 with bit_cnt==WIDTH-1 (completion): the assembled word including the current d is formed, bit_cnt wraps to 0 and the shift register clears.
  - Slot free (dout_valid=0, or dout_valid & dout_ready this edge): dout <= word and dout_valid <= 1 at the same edge. Latency: the word is visible the cycle after the edge that samples the last bit.
  - Slot busy (dout_valid=1 & dout_ready=0): the new word is dropped, dout is unchanged and ovf <= 1.
- Handshake:
  - dout_valid & dout_ready with no simultaneous completion: dout_valid <= 0 next edge; dout holds its last value.
  - Simultaneous accept and completion: dout_valid stays 1 and dout takes the new word (back-to-back, no bubble).
  - dout_ready is ignored while dout_valid=0.
- ovf stays 1 until reset; clr does not clear it.

Optional Feature:
- Macro: S2P_PARITY_CHK_EN.
- When defined:
  - Each frame is WIDTH data bits plus 1 trailing even-parity bit, and bit_cnt counts to WIDTH.
  - Completion occurs on the parity bit.
  - Extra output port par_err (1 bit) is loaded alongside dout: 1 if XOR(data bits, parity bit) != 0.
  - par_err is held with dout, reset value 0, and is not updated when the word is dropped.
- When undefined: no par_err port, and frames are exactly WIDTH bits.

Decomposition:
- Package s2p_pkg:
  - Constant S2P_CNT_W = $clog2(WIDTH+1).
  - Constant S2P_FRAME_LEN (WIDTH, or WIDTH+1 with parity).
  - Enum for completion outcome: LOAD, DROP, NONE.
- Sub-module s2p_bit_counter: wrapping counter with clr, en and a terminal-count output. It is instantiated once and drives the completion decision.

Test Plan:
- WIDTH=8, MSB_FIRST=1, en=1 every cycle, d=1,0,1,1,0,0,1,0 -> dout=8'hB2 and dout_valid=1 one cycle after the 8th bit edge; dout_ready=1 -> dout_valid=0 next edge.
- Same bits with en=0 for 3 cycles between bits 4 and 5 (d toggling during the gap) -> dout=8'hB2; bit_cnt holds at 4 during the gap.
- MSB_FIRST=0, bits 1,0,1,1,0,0,1,0 -> dout=8'h4D.
- dout_ready=0, word 8'hB2 then word 8'hFF -> dout stays 8'hB2 and ovf=1; after dout_ready=1 -> dout_valid=0 and ovf remains 1.
- dout_ready=1 on the exact edge the second word (8'h0F) completes -> dout_valid stays 1, dout=8'h0F, ovf=0.
- clr after 5 bits, then 8 bits 8'hA5 -> dout=8'hA5. reset asserted after 3 bits -> all outputs 0 and bit_cnt=0. With S2P_PARITY_CHK_EN: 8'hB2 + parity 0 -> par_err=0; 8'hB2 + parity 1 -> par_err=1.
